window_sum_actor: RTL and testbench

- Parametrised sliding-window sum actor for the window-computation dataflow graph.
- Consumes signed samples from an input FIFO and keeps the last WINDOW samples in an internal shift register.
- Advances the window by STRIDE samples per output and writes one widened sum per window to an output FIFO.
- Generalises the three-mode stream_comp enable/invoke pair: enable and invoke live in one block, and the block adds configurable stride, width and sequential accumulation.

---
 rtl/window_comp_pkg.sv | 33 +++
 rtl/window_sum_enable.sv | 43 ++++
 rtl/window_sum_actor.sv | 165 ++++++++++++++++
 tb/tb_window_sum_actor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_comp_pkg
// Description : Shared mode encodings and width helpers for the
//               window-computation dataflow actors.
// Revision    : 1.0 - initial release
// ============================================================================
package window_comp_pkg;

    // Actor modes as seen on the mode port
    localparam logic [1:0] SETUP_COMP = 2'd0;
    localparam logic [1:0] COMP       = 2'd1;
    localparam logic [1:0] OUTPUT     = 2'd2;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // FIFO status port width: never narrower than one bit
    function automatic int log2(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_sum_enable.sv
`default_nettype none
// ============================================================================
// Module      : window_sum_enable
// Description : Combinational firing-enable decode for window_sum_actor.
//               i_mode / i_busy / i_first : actor state
//               i_pop_in                  : input FIFO population
//               i_free_space_out          : output FIFO free space
//               o_enable                  : firing allowed this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module window_sum_enable
    import window_comp_pkg::*;
#(
    parameter int WINDOW          = 3,
    parameter int STRIDE          = 1,
    parameter int BUFFER_SIZE     = 5,
    parameter int BUFFER_SIZE_OUT = 1
) (
    input  logic [1:0]                         i_mode,
    input  logic                               i_busy,
    input  logic                               i_first,
    input  logic [log2(BUFFER_SIZE)-1:0]       i_pop_in,
    input  logic [log2(BUFFER_SIZE_OUT)-1:0]   i_free_space_out,
    output logic                               o_enable
);

    logic [31:0] w_need;

    always_comb begin
        w_need   = i_first ? 32'(WINDOW) : 32'(STRIDE);
        o_enable = 1'b0;
        if (!i_busy) begin
            case (i_mode)
                SETUP_COMP: o_enable = (32'(i_pop_in) >= w_need);
                COMP:       o_enable = 1'b1;
                OUTPUT:     o_enable = |i_free_space_out;
                default:    o_enable = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/window_sum_actor.sv
`default_nettype none
// ============================================================================
// Module      : window_sum_actor
// Description : Sliding-window sum actor. SETUP_COMP pops need samples into
//               the window, COMP accumulates the window sequentially, OUTPUT
//               pushes the widened sum.
//   clk, rst             : clock, asynchronous active-high reset
//   pop_in, data_in      : input FIFO population and show-ahead head
//   rd_in                : input FIFO pop strobe
//   free_space_out       : output FIFO free space
//   data_out, wr_out     : window sum and output FIFO push strobe
//   invoke, enable       : scheduler request / firing allowed
//   firing_done, mode    : last cycle of firing / current mode
// Revision    : 1.0 - initial release
// ============================================================================
module window_sum_actor
    import window_comp_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int WINDOW          = 3,
    parameter int STRIDE          = 1,
    parameter int BUFFER_SIZE     = 5,
    parameter int BUFFER_SIZE_OUT = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [log2(BUFFER_SIZE)-1:0]       pop_in,
    input  logic [log2(BUFFER_SIZE_OUT)-1:0]   free_space_out,
    input  logic [WIDTH-1:0]                   data_in,
    output logic                               rd_in,
    output logic [WIDTH+clog2(WINDOW)-1:0]     data_out,
    output logic                               wr_out,
    input  logic                               invoke,
    output logic                               enable,
    output logic                               firing_done,
    output logic [1:0]                         mode
);

    localparam int CW = clog2(WINDOW);
    localparam int SW = WIDTH + CW;
    localparam logic [CW-1:0] c_win_last    = CW'(WINDOW - 1);
    localparam logic [CW-1:0] c_stride_last = CW'(STRIDE - 1);

    logic [1:0]        r_mode, w_mode_nx;
    logic              r_busy, w_busy_nx;
    logic              r_first, w_first_nx;
    logic [CW-1:0]     r_cnt, w_cnt_nx;
    logic              w_last;
    logic              w_accept;
    logic [CW-1:0]     w_need_last;

    logic [WIDTH-1:0]  r_win [WINDOW];
    logic [SW-1:0]     r_acc;
    logic [SW-1:0]     r_dout;
    logic [WIDTH-1:0]  w_sel;
    logic [SW-1:0]     w_ext;

    window_sum_enable #(
        .WINDOW          (WINDOW),
        .STRIDE          (STRIDE),
        .BUFFER_SIZE     (BUFFER_SIZE),
        .BUFFER_SIZE_OUT (BUFFER_SIZE_OUT)
    ) u_enable (
        .i_mode           (r_mode),
        .i_busy           (r_busy),
        .i_first          (r_first),
        .i_pop_in         (pop_in),
        .i_free_space_out (free_space_out),
        .o_enable         (enable)
    );

    assign w_accept    = invoke & enable;
    assign w_need_last = r_first ? c_win_last : c_stride_last;
    assign w_sel       = r_win[r_cnt];
    assign w_ext       = {{(SW-WIDTH){w_sel[WIDTH-1]}}, w_sel};
    assign data_out    = r_dout;
    assign mode        = r_mode;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= SETUP_COMP;
            r_busy  <= 1'b0;
            r_first <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_mode  <= w_mode_nx;
            r_busy  <= w_busy_nx;
            r_first <= w_first_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_mode_nx   = r_mode;
        w_busy_nx   = r_busy;
        w_first_nx  = r_first;
        w_cnt_nx    = r_cnt;
        w_last      = 1'b0;
        rd_in       = 1'b0;
        wr_out      = 1'b0;
        firing_done = 1'b0;
        if (r_busy) begin
            case (r_mode)
                SETUP_COMP: begin
                    rd_in  = 1'b1;
                    w_last = (r_cnt == w_need_last);
                end
                COMP:    w_last = (r_cnt == c_win_last);
                OUTPUT: begin
                    wr_out = 1'b1;
                    w_last = 1'b1;
                end
                default: w_last = 1'b1;
            endcase
            firing_done = w_last;
            if (w_last) begin
                w_busy_nx = 1'b0;
                w_cnt_nx  = '0;
                case (r_mode)
                    SETUP_COMP: begin
                        w_mode_nx  = COMP;
                        w_first_nx = 1'b0;
                    end
                    COMP:    w_mode_nx = OUTPUT;
                    default: w_mode_nx = SETUP_COMP;
                endcase
            end else begin
                w_cnt_nx = r_cnt + 1'b1;
            end
        end else if (w_accept) begin
            // busy rises the cycle after the accepted invoke
            w_busy_nx = 1'b1;
            w_cnt_nx  = '0;
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WINDOW; i++) begin
                r_win[i] <= '0;
            end
            r_acc  <= '0;
            r_dout <= '0;
        end else begin
            if (rd_in) begin
                r_win[0] <= data_in;
                for (int i = 1; i < WINDOW; i++) begin
                    r_win[i] <= r_win[i-1];
                end
            end
            // first accumulation cycle loads instead of adding, clearing the sum
            if (r_busy && (r_mode == COMP)) begin
                r_acc <= (r_cnt == '0) ? w_ext : (r_acc + w_ext);
            end
            // captured at acceptance so data_out is valid alongside wr_out
            if (w_accept && (r_mode == OUTPUT)) begin
                r_dout <= r_acc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_window_sum_actor.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_sum_actor
// Description : Directed self-checking bench for window_sum_actor
//               (default config plus a STRIDE=2 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_sum_actor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  pop_in;
    logic [0:0]  free_space_out;
    logic [15:0] data_in;
    logic        invoke;
    logic        sel;

    logic        inv_a, inv_b;
    logic        rd_a, wr_a, en_a, done_a, rd_b, wr_b, en_b, done_b;
    logic [17:0] dout_a, dout_b;
    logic [1:0]  mode_a, mode_b;
    logic        w_rd, w_wr, w_en, w_done;
    logic [17:0] w_dout;
    logic [1:0]  w_mode;

    assign inv_a  = invoke & ~sel;
    assign inv_b  = invoke & sel;
    assign w_rd   = sel ? rd_b   : rd_a;
    assign w_wr   = sel ? wr_b   : wr_a;
    assign w_en   = sel ? en_b   : en_a;
    assign w_done = sel ? done_b : done_a;
    assign w_dout = sel ? dout_b : dout_a;
    assign w_mode = sel ? mode_b : mode_a;

    window_sum_actor u_dut (
        .clk(clk), .rst(rst), .pop_in(pop_in), .free_space_out(free_space_out),
        .data_in(data_in), .rd_in(rd_a), .data_out(dout_a), .wr_out(wr_a),
        .invoke(inv_a), .enable(en_a), .firing_done(done_a), .mode(mode_a)
    );

    window_sum_actor #(.STRIDE(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .pop_in(pop_in), .free_space_out(free_space_out),
        .data_in(data_in), .rd_in(rd_b), .data_out(dout_b), .wr_out(wr_b),
        .invoke(inv_b), .enable(en_b), .firing_done(done_b), .mode(mode_b)
    );

    int q[$];
    int outs[$];
    int rdf[$];
    int rd_cnt, wr_cnt;
    int checks, failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int get_out(input int i);
        return (outs.size() > i) ? outs[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int get_rdf(input int i);
        return (rdf.size() > i) ? rdf[i] : -1;
    endfunction

    task automatic refresh();
        pop_in  = (q.size() > 7) ? 3'd7 : 3'(q.size());
        data_in = (q.size() > 0) ? 16'(q[0]) : 16'd0;
    endtask

    task automatic push(input int v);
        q.push_back(v);
        refresh();
        #1;
    endtask

    // One clock: sample strobes away from the edge, consume FIFO head on rd_in
    task automatic step();
        logic r;
        r = w_rd;
        if (w_wr) begin
            wr_cnt++;
            outs.push_back(32'(w_dout));
        end
        if (r) rd_cnt++;
        @(posedge clk);
        #1;
        if (r) void'(q.pop_front());
        invoke = 1'b0;
        refresh();
        @(negedge clk);
    endtask

    task automatic fire(output int nrd);
        int  r0;
        bit  ok;
        r0 = rd_cnt;
        ok = 1'b0;
        invoke = 1'b1;
        step();
        for (int i = 0; i < 8 && !ok; i++) begin
            logic d;
            d = w_done;
            step();
            if (d) ok = 1'b1;
        end
        chk("fire_done", 32'(ok), 32'd1);
        nrd = rd_cnt - r0;
    endtask

    task automatic run_idle();
        int n;
        for (int k = 0; k < 40; k++) begin
            if (!w_en) break;
            fire(n);
            rdf.push_back(n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        invoke = 1'b0;
        q.delete();
        outs.delete();
        rdf.delete();
        rd_cnt = 0;
        wr_cnt = 0;
        refresh();
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        checks = 0; failures = 0;
        sel = 1'b0; invoke = 1'b0; free_space_out = 1'b1; rst = 1'b1;
        rd_cnt = 0; wr_cnt = 0;
        refresh();
        @(negedge clk);
        step();
        // ---------------- reset state
        chk("rst_mode",  32'(w_mode), 32'd0);
        chk("rst_rd",    32'(w_rd),   32'd0);
        chk("rst_wr",    32'(w_wr),   32'd0);
        chk("rst_done",  32'(w_done), 32'd0);
        chk("rst_dout",  32'(w_dout), 32'd0);
        rst = 1'b0;
        step();

        // ---------------- default config, enable gating
        push(1); push(2);
        chk("en_pop2_first", 32'(w_en), 32'd0);
        push(3);
        chk("en_pop3_first", 32'(w_en), 32'd1);
        fire(n); fire(n); fire(n);
        chk("out0_6", 32'(get_out(0)), 32'd6);
        push(4);
        chk("en_pop1_after", 32'(w_en), 32'd1);
        push(5);
        run_idle();
        chk("out1_9",  32'(get_out(1)), 32'd9);
        chk("out2_12", 32'(get_out(2)), 32'd12);
        chk("rd_cnt5", 32'(rd_cnt), 32'd5);
        chk("wr_cnt3", 32'(wr_cnt), 32'd3);
        chk("idle_mode", 32'(w_mode), 32'd0);

        // ---------------- signed data
        do_reset();
        push(-5); push(2); push(1);
        run_idle();
        chk("signed_neg2", 32'(w_dout), 32'h3FFFE);
        do_reset();
        push(32767); push(32767); push(32767);
        run_idle();
        chk("max_no_wrap", 32'(w_dout), 32'd98301);

        // ---------------- invoke coincident with firing_done, then backpressure
        do_reset();
        free_space_out = 1'b0;
        push(10); push(20); push(30);
        invoke = 1'b1;
        step(); step(); step();
        chk("setup_done_T3", 32'(w_done), 32'd1);
        invoke = 1'b1;
        step();
        chk("coinc_inv_ignored_en", 32'(w_en), 32'd1);
        chk("coinc_mode_comp", 32'(w_mode), 32'd1);
        fire(n);
        chk("bp_mode_out", 32'(w_mode), 32'd2);
        chk("bp_en0", 32'(w_en), 32'd0);
        invoke = 1'b1;
        step(); step();
        chk("bp_no_wr", 32'(wr_cnt), 32'd0);
        chk("bp_mode_hold", 32'(w_mode), 32'd2);
        free_space_out = 1'b1;
        #1;
        chk("bp_en1", 32'(w_en), 32'd1);
        fire(n);
        chk("bp_wr1", 32'(wr_cnt), 32'd1);
        chk("bp_sum60", 32'(get_out(0)), 32'd60);
        chk("bp_mode_setup", 32'(w_mode), 32'd0);

        // ---------------- STRIDE=2
        do_reset();
        sel = 1'b1;
        #1;
        for (int v = 1; v <= 7; v++) push(v);
        run_idle();
        chk("s2_out0_6",  32'(get_out(0)), 32'd6);
        chk("s2_out1_12", 32'(get_out(1)), 32'd12);
        chk("s2_out2_18", 32'(get_out(2)), 32'd18);
        chk("s2_rd_first3", 32'(get_rdf(0)), 32'd3);
        chk("s2_rd_second2", 32'(get_rdf(3)), 32'd2);
        chk("s2_rd_third2", 32'(get_rdf(6)), 32'd2);
        chk("s2_rd_total7", 32'(rd_cnt), 32'd7);
        sel = 1'b0;
        #1;

        // ---------------- reset during accumulation
        do_reset();
        push(1); push(2); push(3);
        run_idle();
        chk("pre_rst_dout6", 32'(w_dout), 32'd6);
        push(4);
        fire(n);
        invoke = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_mode", 32'(w_mode), 32'd0);
        chk("midrst_dout", 32'(w_dout), 32'd0);
        chk("midrst_done", 32'(w_done), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("midrst_no_rd", 32'(w_rd), 32'd0);
        push(7); push(8);
        chk("midrst_need3_en0", 32'(w_en), 32'd0);
        push(9);
        chk("midrst_need3_en1", 32'(w_en), 32'd1);
        run_idle();
        chk("midrst_sum24", 32'(w_dout), 32'd24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
